tlul_sram_responder: RTL



---
 rtl/tlul_sram_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tlul_sram_responder.sv
// TL-UL device-side responder in front of a single-port SRAM with 1-cycle read latency.
// Ports:
//   clk_i, rst_ni    clock and asynchronous active-low reset
//   tl_i / tl_o      TL-UL request (plus d_ready) / response (plus a_ready)
//   req_o, we_o      SRAM access strobe and write enable (we_o qualified by req_o)
//   addr_o           SRAM word address
//   wdata_o, wmask_o SRAM write data and bit-level write mask
//   rdata_i          SRAM read data, valid the cycle after a read strobe
// One request is outstanding at a time. The response register is reused, so a new
// request can be accepted in the same cycle that the previous response handshakes.

package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_sram_responder
  import tlul_pkg::*;
#(
  parameter int unsigned SramAw   = 10,
  parameter logic [31:0] ErrRdata = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tl_h2d_t           tl_i,
  output tl_d2h_t           tl_o,
  output logic              req_o,
  output logic              we_o,
  output logic [SramAw-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       wmask_o,
  input  logic [31:0]       rdata_i
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StRdWait = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  d_opcode_q, d_opcode_d;
  logic [1:0]  d_size_q, d_size_d;
  logic [7:0]  d_source_q, d_source_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_error_q, d_error_d;

  logic       is_get, is_put_full, is_put;
  logic [3:0] lane_mask;
  logic       misaligned;
  logic       err;
  logic       a_ready;
  logic       accept;

  assign is_get      = (tl_i.a_opcode == Get);
  assign is_put_full = (tl_i.a_opcode == PutFullData);
  assign is_put      = is_put_full || (tl_i.a_opcode == PutPartialData);

  // Byte lanes addressed by address/size; size 3 is rejected separately.
  always_comb begin
    lane_mask  = 4'h0;
    misaligned = 1'b0;
    case (tl_i.a_size)
      2'd0: lane_mask = 4'b0001 << tl_i.a_address[1:0];
      2'd1: begin
        lane_mask  = tl_i.a_address[1] ? 4'b1100 : 4'b0011;
        misaligned = tl_i.a_address[0];
      end
      2'd2: begin
        lane_mask  = 4'hF;
        misaligned = |tl_i.a_address[1:0];
      end
      default: begin
        lane_mask  = 4'h0;
        misaligned = 1'b0;
      end
    endcase
  end

  assign err = !(is_get || is_put)
            || (tl_i.a_size > 2'd2)
            || misaligned
            || (is_put && |(tl_i.a_mask & ~lane_mask))
            || (is_put_full && (tl_i.a_mask != lane_mask));

  assign a_ready = (state_q == StIdle) || ((state_q == StResp) && tl_i.d_ready);
  assign accept  = tl_i.a_valid && a_ready;

  assign req_o   = accept && !err;
  assign we_o    = is_put;
  assign addr_o  = tl_i.a_address[SramAw+1:2];
  assign wdata_o = tl_i.a_data;

  always_comb begin
    wmask_o = '0;
    for (int i = 0; i < 4; i++) begin
      wmask_o[8*i +: 8] = {8{tl_i.a_mask[i]}};
    end
  end

  always_comb begin
    state_d    = state_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;

    case (state_q)
      StRdWait: begin
        d_data_d = rdata_i;
        state_d  = StResp;
      end
      StResp: begin
        if (tl_i.d_ready) state_d = StIdle;
      end
      default: ;
    endcase

    // An accept from IDLE or from a completing RESP overrides the above.
    if (accept) begin
      d_opcode_d = is_get ? AccessAckData : AccessAck;
      d_size_d   = tl_i.a_size;
      d_source_d = tl_i.a_source;
      d_error_d  = err;
      if (is_get && !err) begin
        state_d = StRdWait;
      end else begin
        state_d  = StResp;
        d_data_d = (is_get && err) ? ErrRdata : 32'h0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      d_opcode_q <= AccessAck;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;
      d_source_q <= d_source_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = (state_q == StResp);
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_param  = 3'h0;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = a_ready;
  end

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:SramAw+2]};

endmodule
